md5_msg_padder: RTL and testbench

- Sits directly upstream of the MD5 round engine behind the md5_data conduit.
- Accepts a candidate message as a byte stream and buffers it.
- Emits one MD5-padded 512-bit block as 16 little-endian 32-bit words with a valid/ready handshake.
- Supports single-block messages only: 0 to 55 bytes, which covers the password candidates the decryption flow hashes.

---
 rtl/md5_pkg.sv | 37 +++
 rtl/md5_msg_padder.sv | 115 +++++++++++
 tb/tb_md5_msg_padder.sv | 371 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/md5_pkg.sv
// rtl/md5_pkg.sv - shared MD5 constants, padder state encoding and padding byte function
package md5_pkg;

    localparam int MD5_BLOCK_BYTES    = 64;
    localparam int MD5_MAX_SINGLE_LEN = 55;

    typedef enum logic [1:0] {
        PAD_COLLECT = 2'd0,
        PAD_EMIT    = 2'd1,
        PAD_DRAIN   = 2'd2
    } pad_state_e;

    // Byte idx of the padded single block for a message of len bytes; data is
    // the buffered byte at idx and is only used when idx falls inside the message.
    function automatic logic [7:0] pad_byte(
        input logic [5:0] idx,
        input logic [6:0] len,
        input logic [7:0] data
    );
        logic [63:0] bit_len;
        logic [63:0] shifted;
        logic [5:0]  len_byte;
        bit_len  = {54'b0, len, 3'b000};
        len_byte = idx - 6'd56;
        shifted  = bit_len >> {len_byte, 3'b000};
        if (7'(idx) < len) begin
            return data;
        end else if (7'(idx) == len) begin
            return 8'h80;
        end else if (idx < 6'd56) begin
            return 8'h00;
        end else begin
            return shifted[7:0];
        end
    endfunction

endpackage

// File: rtl/md5_msg_padder.sv
// rtl/md5_msg_padder.sv - buffers a byte-stream message and emits one MD5-padded 512-bit block
module md5_msg_padder
    import md5_pkg::*;
#(
    parameter int MAX_LEN = MD5_MAX_SINGLE_LEN,
    parameter int LEN_W   = 7
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_data,
    input  logic        in_last,
    input  logic        in_empty,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [3:0]  out_idx,
    output logic        out_last,
    output logic        err,
    output logic        busy
);

    localparam logic [LEN_W-1:0] LEN_LIMIT = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] LEN_SAT   = LEN_W'(MAX_LEN + 1);

    pad_state_e       state_q, state_d;
    logic [LEN_W-1:0] count_q, count_d;
    logic [3:0]       idx_q, idx_d;
    logic             buf_we;
    logic [31:0]      padded_word;

    // Never cleared: padding masks anything at or beyond the current length.
    logic [7:0] msg_buf [MD5_BLOCK_BYTES];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= PAD_COLLECT;
            count_q <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            idx_q   <= idx_d;
        end
    end

    always_ff @(posedge clk) begin
        if (buf_we) begin
            msg_buf[count_q[5:0]] <= in_data;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        idx_d   = idx_q;
        buf_we  = 1'b0;
        case (state_q)
            PAD_COLLECT: begin
                if (in_valid) begin
                    if (!(in_last && in_empty)) begin
                        if (count_q < LEN_LIMIT) begin
                            buf_we = 1'b1;
                        end
                        if (count_q != LEN_SAT) begin
                            count_d = count_q + LEN_W'(1);
                        end
                    end
                    if (in_last) begin
                        state_d = (count_d <= LEN_LIMIT) ? PAD_EMIT : PAD_DRAIN;
                    end
                end
            end
            PAD_EMIT: begin
                if (out_ready) begin
                    if (idx_q == 4'd15) begin
                        idx_d   = '0;
                        count_d = '0;
                        state_d = PAD_COLLECT;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            PAD_DRAIN: begin
                count_d = '0;
                state_d = PAD_COLLECT;
            end
            default: begin
                count_d = '0;
                idx_d   = '0;
                state_d = PAD_COLLECT;
            end
        endcase
    end

    // Little-endian packing: byte 4w lands in bits [7:0] of word w.
    always_comb begin
        padded_word = '0;
        for (int b = 0; b < 4; b++) begin
            padded_word[8*b +: 8] = pad_byte({idx_q, 2'(b)}, 7'(count_q),
                                             msg_buf[{idx_q, 2'(b)}]);
        end
    end

    assign in_ready  = (state_q == PAD_COLLECT);
    assign out_valid = (state_q == PAD_EMIT);
    assign out_data  = out_valid ? padded_word : 32'h0;
    assign out_idx   = idx_q;
    assign out_last  = out_valid && (idx_q == 4'd15);
    assign err       = (state_q == PAD_DRAIN);
    assign busy      = (state_q != PAD_COLLECT);

endmodule

// File: tb/tb_md5_msg_padder.sv
// tb/tb_md5_msg_padder.sv - self-checking bench for md5_msg_padder
module tb_md5_msg_padder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_data = 8'h00;
    logic        in_last = 1'b0;
    logic        in_empty = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic [3:0]  out_idx;
    logic        out_last;
    logic        err;
    logic        busy;

    int checks = 0;
    int failures = 0;

    logic [7:0]  msg [64];
    int          got_cnt;
    logic [31:0] got_data [16];
    logic [3:0]  got_idx [16];
    logic        got_last [16];
    int          first_valid_at;
    int          stall_bad;
    int          in_ready_bad;

    md5_msg_padder dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_empty  (in_empty),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .err       (err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Reference: build the full 64-byte padded block as an array, then pick word w.
    function automatic logic [31:0] model_word(input int len, input int w);
        logic [7:0]  p [64];
        logic [63:0] bits;
        bits = 64'(len) * 64'd8;
        for (int i = 0; i < 64; i++) begin
            if (i < len)       p[i] = msg[i];
            else if (i == len) p[i] = 8'h80;
            else if (i < 56)   p[i] = 8'h00;
            else               p[i] = 8'((bits >> (8 * (i - 56))) & 64'hff);
        end
        return {p[4*w+3], p[4*w+2], p[4*w+1], p[4*w]};
    endfunction

    task automatic send_msg(input int len, input bit trailing_empty, input bit gaps);
        int beats;
        bit extra;
        extra = trailing_empty || (len == 0);
        beats = len + (extra ? 1 : 0);
        for (int b = 0; b < beats; b++) begin
            if (gaps) begin
                int idle;
                idle = $urandom_range(0, 2);
                for (int g = 0; g < idle; g++) begin
                    in_valid = 1'b0;
                    @(posedge clk); #1;
                end
            end
            in_valid = 1'b1;
            if (b < len) begin
                in_data  = msg[b];
                in_empty = 1'b0;
                in_last  = (b == len - 1) && !extra;
            end else begin
                in_data  = 8'($urandom);
                in_empty = 1'b1;
                in_last  = 1'b1;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_empty = 1'b0;
    endtask

    task automatic receive_block(input bit rand_ready);
        int cycles;
        bit stalled;
        logic [31:0] pd;
        logic [3:0]  pi;
        logic        pl;
        got_cnt = 0;
        cycles = 0;
        stalled = 0;
        first_valid_at = -1;
        stall_bad = 0;
        in_ready_bad = 0;
        pd = '0; pi = '0; pl = 1'b0;
        while (got_cnt < 16 && cycles < 200) begin
            out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            if (out_valid) begin
                if (first_valid_at < 0) first_valid_at = cycles;
                if (in_ready) in_ready_bad++;
                if (stalled && (out_data !== pd || out_idx !== pi || out_last !== pl)) stall_bad++;
                if (out_ready) begin
                    got_data[got_cnt] = out_data;
                    got_idx[got_cnt]  = out_idx;
                    got_last[got_cnt] = out_last;
                    got_cnt++;
                    stalled = 0;
                end else begin
                    pd = out_data; pi = out_idx; pl = out_last;
                    stalled = 1;
                end
            end
            @(posedge clk); #1;
            cycles++;
        end
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({in_ready, out_valid, out_idx, out_last, err, busy, out_data} !== {1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 32'h0}) begin
            failures++;
            $display("FAIL reset_values: got rdy=%b v=%b idx=%0d last=%b err=%b busy=%b data=%h, want rdy=1 v=0 idx=0 last=0 err=0 busy=0 data=0",
                     in_ready, out_valid, out_idx, out_last, err, busy, out_data);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_abc();
        logic [31:0] exp;
        msg[0] = 8'h61; msg[1] = 8'h62; msg[2] = 8'h63;
        send_msg(3, 1'b0, 1'b0);
        receive_block(1'b0);
        checks++;
        if (first_valid_at !== 0) begin
            failures++;
            $display("FAIL abc_latency: first out_valid after %0d cycles, want 0 (one cycle after last byte)", first_valid_at);
        end
        checks++;
        if (got_cnt !== 16) begin
            failures++;
            $display("FAIL abc_count: got %0d words, want 16", got_cnt);
        end
        for (int w = 0; w < got_cnt; w++) begin
            exp = (w == 0) ? 32'h80636261 : (w == 14) ? 32'h00000018 : 32'h0;
            checks++;
            if (got_data[w] !== exp || got_idx[w] !== 4'(w) || got_last[w] !== (w == 15)) begin
                failures++;
                $display("FAIL abc_word%0d: got data=%h idx=%0d last=%b, want data=%h idx=%0d last=%b",
                         w, got_data[w], got_idx[w], got_last[w], exp, w, (w == 15));
            end
        end
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL abc_return: got in_ready=%b busy=%b, want 1 0", in_ready, busy);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_empty();
        logic [31:0] exp;
        send_msg(0, 1'b1, 1'b0);
        receive_block(1'b0);
        checks++;
        if (got_cnt !== 16) begin
            failures++;
            $display("FAIL empty_count: got %0d words, want 16", got_cnt);
        end
        for (int w = 0; w < got_cnt; w++) begin
            exp = (w == 0) ? 32'h00000080 : 32'h0;
            checks++;
            if (got_data[w] !== exp) begin
                failures++;
                $display("FAIL empty_word%0d: got %h, want %h", w, got_data[w], exp);
            end
        end
    endtask

    task automatic test_max_len();
        logic [31:0] exp;
        for (int i = 0; i < 55; i++) msg[i] = 8'h61;
        send_msg(55, 1'b0, 1'b0);
        receive_block(1'b0);
        checks++;
        if (got_cnt !== 16) begin
            failures++;
            $display("FAIL max_len_count: got %0d words, want 16", got_cnt);
        end
        for (int w = 0; w < got_cnt; w++) begin
            exp = (w <= 12) ? 32'h61616161 : (w == 13) ? 32'h80616161 : (w == 14) ? 32'h000001B8 : 32'h0;
            checks++;
            if (got_data[w] !== exp) begin
                failures++;
                $display("FAIL max_len_word%0d: got %h, want %h", w, got_data[w], exp);
            end
        end
    endtask

    task automatic test_overflow();
        int saw_valid;
        int err_cycles;
        for (int i = 0; i < 56; i++) msg[i] = 8'h61;
        send_msg(56, 1'b0, 1'b0);
        saw_valid = 0;
        err_cycles = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (out_valid) saw_valid++;
            if (err) err_cycles++;
            if (c == 0) begin
                checks++;
                if (err !== 1'b1) begin
                    failures++;
                    $display("FAIL overflow_err_timing: err=%b in cycle after last byte, want 1", err);
                end
            end
            @(posedge clk); #1;
        end
        checks++;
        if (err_cycles !== 1 || saw_valid !== 0) begin
            failures++;
            $display("FAIL overflow_drop: err for %0d cycles, out_valid for %0d cycles, want 1 and 0", err_cycles, saw_valid);
        end
        msg[0] = 8'h61;
        send_msg(1, 1'b0, 1'b0);
        receive_block(1'b0);
        checks++;
        if (got_cnt !== 16 || got_data[0] !== 32'h00008061 || got_data[1] !== 32'h0 || got_data[14] !== 32'h8) begin
            failures++;
            $display("FAIL stale_mask: got n=%0d w0=%h w1=%h w14=%h, want n=16 w0=00008061 w1=0 w14=00000008",
                     got_cnt, got_data[0], got_data[1], got_data[14]);
        end
    endtask

    task automatic test_backpressure();
        msg[0] = 8'h61; msg[1] = 8'h62; msg[2] = 8'h63;
        send_msg(3, 1'b0, 1'b0);
        receive_block(1'b1);
        checks++;
        if (got_cnt !== 16 || stall_bad !== 0 || in_ready_bad !== 0) begin
            failures++;
            $display("FAIL backpressure: words=%0d unstable_stalls=%0d in_ready_during_emit=%0d, want 16 0 0",
                     got_cnt, stall_bad, in_ready_bad);
        end
        for (int w = 0; w < got_cnt; w++) begin
            checks++;
            if (got_idx[w] !== 4'(w) || got_data[w] !== model_word(3, w)) begin
                failures++;
                $display("FAIL backpressure_word%0d: got idx=%0d data=%h, want idx=%0d data=%h",
                         w, got_idx[w], got_data[w], w, model_word(3, w));
            end
        end
    endtask

    task automatic test_reset_mid_emit();
        int cycles;
        msg[0] = 8'h61; msg[1] = 8'h62; msg[2] = 8'h63;
        send_msg(3, 1'b0, 1'b0);
        out_ready = 1'b1;
        cycles = 0;
        @(negedge clk);
        while (!(out_valid && out_idx == 4'd7) && cycles < 40) begin
            @(negedge clk);
            cycles++;
        end
        checks++;
        if (cycles >= 40) begin
            failures++;
            $display("FAIL reset_mid_emit_reach: idx 7 not reached within 40 cycles, got idx=%0d", out_idx);
        end
        reset = 1'b1;
        out_ready = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({in_ready, out_valid, out_idx, out_last, err, busy, out_data} !== {1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 32'h0}) begin
            failures++;
            $display("FAIL reset_mid_emit: got rdy=%b v=%b idx=%0d last=%b err=%b busy=%b data=%h, want reset values",
                     in_ready, out_valid, out_idx, out_last, err, busy, out_data);
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_emit_partial: out_valid=%b after abort, want 0", out_valid);
        end
        @(posedge clk); #1;
        send_msg(3, 1'b0, 1'b0);
        receive_block(1'b0);
        for (int w = 0; w < 16; w++) begin
            checks++;
            if (w >= got_cnt || got_idx[w] !== 4'(w) || got_data[w] !== model_word(3, w)) begin
                failures++;
                $display("FAIL reset_recover_word%0d: got n=%0d idx=%0d data=%h, want idx=%0d data=%h",
                         w, got_cnt, got_idx[w], got_data[w], w, model_word(3, w));
            end
        end
    endtask

    task automatic test_random();
        int len;
        int bad;
        for (int m = 0; m < 24; m++) begin
            len = $urandom_range(0, 60);
            for (int i = 0; i < len; i++) msg[i] = 8'($urandom);
            send_msg(len, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            if (len > 55) begin
                @(negedge clk);
                checks++;
                if (err !== 1'b1 || out_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL random_overflow len=%0d: got err=%b out_valid=%b, want 1 0", len, err, out_valid);
                end
                @(posedge clk); #1;
            end else begin
                receive_block(1'b1);
                bad = 0;
                for (int w = 0; w < 16; w++) begin
                    if (w >= got_cnt || got_idx[w] !== 4'(w) || got_last[w] !== (w == 15)
                        || got_data[w] !== model_word(len, w)) begin
                        bad++;
                        if (bad == 1)
                            $display("FAIL random_block len=%0d word%0d: got n=%0d idx=%0d last=%b data=%h, want data=%h",
                                     len, w, got_cnt, got_idx[w], got_last[w], got_data[w], model_word(len, w));
                    end
                end
                checks++;
                if (bad != 0 || stall_bad != 0) begin
                    failures++;
                    if (bad == 0)
                        $display("FAIL random_stall len=%0d: %0d unstable stalls, want 0", len, stall_bad);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_abc();
        test_empty();
        test_max_len();
        test_overflow();
        test_backpressure();
        test_reset_mid_emit();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
